keypad_scanner: RTL and testbench

Matrix-keypad scanner for the PmodKYPD 4x4 keypad on the Nexys4 DDR. It is the input-side counterpart of the multiplexed seven-segment output path. It drives one keypad column low at a time, samples the active-low rows, and debounces whole-matrix scan results. It emits a debounced hex key code with a one-cycle press strobe, which the display path and control FSMs consume directly.

---
 rtl/keypad_pkg.sv | 56 +++++
 rtl/scan_tick_gen.sv | 29 ++
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, keymap and scan classification for the keypad scanner
// Purpose: scan-result type, FSM state enum, 16-entry keymap indexed {row,col},
//          and a helper that reduces a 16-bit key matrix to NONE/SINGLE/MULTI.
// Ports: none (package).
package keypad_pkg;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_e;

  // code is forced to 0 for NONE/MULTI so whole-struct equality is meaningful
  typedef struct packed {
    res_kind_e  kind;
    logic [3:0] code;
  } scan_res_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_MULTI   = 2'd2
  } state_e;

  localparam scan_res_t RES_NONE_VAL = '{kind: RES_NONE, code: 4'h0};

  // Nibble at index {row,col}; rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEYMAP[{idx, 2'b00} +: 4];
  endfunction

  function automatic scan_res_t classify(input logic [15:0] keys);
    scan_res_t  res;
    logic [4:0] cnt;
    logic [3:0] idx;
    cnt = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) begin
        cnt = cnt + 5'd1;
        idx = 4'(i);
      end
    end
    res = RES_NONE_VAL;
    if (cnt == 5'd1) begin
      res.kind = RES_SINGLE;
      res.code = key_lookup(idx);
    end else if (cnt > 5'd1) begin
      res.kind = RES_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running dwell counter with a one-cycle tick
// Purpose: counts 0..DIV-1 and asserts tick_o while the count is DIV-1.
// Ports: clk_i clock, rst_i async active-high reset, tick_o one-cycle tick.
module scan_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with whole-scan debounce
// Purpose: drives one column low at a time, samples synchronized active-low
//          rows at end of dwell, debounces full-scan results and reports keys.
// Ports: clk_i clock, rst_i async active-high reset, row_n_i[3:0] rows (active-low),
//        col_n_o[3:0] column drive (one low), key_code_o[3:0] committed key,
//        key_valid_o new-key strobe, key_down_o key held, multi_key_o 2+ keys held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_n_i,
  output logic [3:0] col_n_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_down_o,
  output logic       multi_key_o
);

  localparam int         DIV = CLK_HZ / SCAN_HZ;
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  logic       tick;
  logic [3:0] row_s1_q, row_s2_q;
  logic [1:0] col_idx_q, col_idx_d;
  logic [15:0] keys_q, keys_d;
  logic       scan_done;
  scan_res_t  scan_res;
  scan_res_t  prev_q, prev_d;
  scan_res_t  committed_q, committed_d;
  logic [3:0] stable_q, stable_d;
  logic       commit;
  state_e     state_q, state_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_down_q, key_down_d;
  logic       multi_key_q, multi_key_d;

  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Rows are closed-low; store them as 1 = pressed in the matrix at {row,col}
  always_comb begin
    keys_d    = keys_q;
    col_idx_d = col_idx_q;
    if (tick) begin
      for (int r = 0; r < 4; r++) keys_d[{2'(r), col_idx_q}] = ~row_s2_q[r];
      col_idx_d = col_idx_q + 2'd1;
    end
  end

  // keys_d already contains column 3's fresh sample, so the result is complete
  assign scan_done = tick && (col_idx_q == 2'd3);
  assign scan_res  = classify(keys_d);

  always_comb begin
    prev_d      = prev_q;
    stable_d    = stable_q;
    committed_d = committed_q;
    commit      = 1'b0;
    if (scan_done) begin
      prev_d = scan_res;
      if (scan_res == prev_q) stable_d = (stable_q >= DEB) ? DEB : stable_q + 4'd1;
      else                    stable_d = 4'd1;
      if (stable_d == DEB && scan_res != committed_q) begin
        commit      = 1'b1;
        committed_d = scan_res;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    multi_key_d = multi_key_q;
    if (commit) begin
      case (scan_res.kind)
        RES_SINGLE: begin
          // Leaving MULTI always re-strobes, even for the same code
          if (state_q != ST_PRESSED || scan_res.code != key_code_q) key_valid_d = 1'b1;
          key_code_d  = scan_res.code;
          key_down_d  = 1'b1;
          multi_key_d = 1'b0;
          state_d     = ST_PRESSED;
        end
        RES_MULTI: begin
          key_down_d  = 1'b0;
          multi_key_d = 1'b1;
          state_d     = ST_MULTI;
        end
        default: begin
          key_down_d  = 1'b0;
          multi_key_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      col_idx_q   <= 2'd0;
      keys_q      <= '0;
      prev_q      <= RES_NONE_VAL;
      committed_q <= RES_NONE_VAL;
      stable_q    <= '0;
      state_q     <= ST_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      row_s1_q    <= row_n_i;
      row_s2_q    <= row_s1_q;
      col_idx_q   <= col_idx_d;
      keys_q      <= keys_d;
      prev_q      <= prev_d;
      committed_q <= committed_d;
      stable_q    <= stable_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
      multi_key_q <= multi_key_d;
    end
  end

  // Column moves on the edge that latches the tick sample, never mid-sample
  assign col_n_o     = ~(4'b0001 << col_idx_q);
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_down_o  = key_down_q;
  assign multi_key_o = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        multi_key;
  logic [15:0] keys;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          strobes;
  int          mon_cyc;
  int          first_cyc;
  logic [3:0]  last_code;
  logic        down_low;
  logic [3:0]  exp_col;
  int          guard;

  always #5 clk = ~clk;

  // Keypad model: closed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_scanner #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .row_n_i     (row_n),
    .col_n_o     (col_n),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_down_o  (key_down),
    .multi_key_o (multi_key)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    strobes   = 0;
    mon_cyc   = 0;
    first_cyc = -1;
    down_low  = 1'b0;
    last_code = 4'hx;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      mon_cyc++;
      if (key_valid === 1'b1) begin
        strobes++;
        last_code = key_code;
        if (first_cyc < 0) first_cyc = mon_cyc;
      end
      if (key_down !== 1'b1) down_low = 1'b1;
    end
  endtask

  // Leaves rst low at a negedge, so the next posedge is the first counting edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_key_code", key_code, 4'h0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_down", key_down, 1'b0);
    chk("rst_multi_key", multi_key, 1'b0);

    // Free run: 10 cycles per column
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_col = ~(4'b0001 << ((i / 10) % 4));
      chk($sformatf("freerun_col_%0d", i), col_n, exp_col);
      @(negedge clk);
    end

    // Key 5 held
    clear_mon();
    keys = 16'h0020;
    run(122);
    chk("k5_within_122", (first_cyc > 0 && first_cyc <= 122), 1'b1);
    run(80);
    chk("k5_strobes", strobes, 1);
    chk("k5_code", last_code, 4'h5);
    chk("k5_down", key_down, 1'b1);
    clear_mon();
    keys = '0;
    run(130);
    chk("k5_rel_strobes", strobes, 0);
    chk("k5_rel_down", key_down, 1'b0);

    // Key D bouncing, phased so no two consecutive scans see it pressed
    do_reset();
    run(30);
    clear_mon();
    for (int i = 0; i < 100; i++) begin
      keys = (((i / 15) % 2) == 0) ? 16'h8000 : 16'h0000;
      run(1);
    end
    chk("bounce_quiet", strobes, 0);
    keys = 16'h8000;
    run(120);
    chk("bounce_strobes", strobes, 1);
    chk("bounce_code", last_code, 4'hD);

    // Multi-key: 1, then 1+2, then 2
    keys = '0;
    run(130);
    clear_mon();
    keys = 16'h0001;
    run(130);
    chk("m1_strobes", strobes, 1);
    chk("m1_code", last_code, 4'h1);
    clear_mon();
    keys = 16'h0003;
    run(130);
    chk("m12_multi", multi_key, 1'b1);
    chk("m12_down", key_down, 1'b0);
    chk("m12_code", key_code, 4'h1);
    chk("m12_strobes", strobes, 0);
    clear_mon();
    keys = 16'h0002;
    run(130);
    chk("m2_strobes", strobes, 1);
    chk("m2_code", last_code, 4'h2);
    chk("m2_multi", multi_key, 1'b0);
    chk("m2_down", key_down, 1'b1);

    // Rollover 7 -> 0
    keys = '0;
    run(130);
    clear_mon();
    keys = 16'h0100;
    run(130);
    chk("r7_strobes", strobes, 1);
    chk("r7_code", last_code, 4'h7);
    clear_mon();
    keys = 16'h1000;
    run(130);
    chk("r0_strobes", strobes, 1);
    chk("r0_code", last_code, 4'h0);
    chk("r0_down_held", down_low, 1'b0);

    // Reset mid-dwell on column 2 with A held
    keys = '0;
    run(130);
    clear_mon();
    keys = 16'h0008;
    run(130);
    chk("ra_strobes", strobes, 1);
    chk("ra_code", last_code, 4'hA);
    guard = 0;
    while (col_n !== 4'b1011 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ra_found_col2", col_n, 4'b1011);
    run(3);
    #2 rst = 1'b1;
    #1;
    chk("ra_rst_col_n", col_n, 4'b1110);
    chk("ra_rst_code", key_code, 4'h0);
    chk("ra_rst_valid", key_valid, 1'b0);
    chk("ra_rst_down", key_down, 1'b0);
    chk("ra_rst_multi", multi_key, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    run(130);
    chk("ra_again_strobes", strobes, 1);
    chk("ra_again_code", last_code, 4'hA);
    chk("ra_again_down", key_down, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
